alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage_pkg.sv | 45 ++++
 rtl/fwd_select.sv | 42 ++++
 rtl/alu_operand_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_operand_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// ============================================================================
// Module      : alu_operand_stage_pkg
// Description : Shared ALU opcodes, register-index width and forwarding helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_operand_stage_pkg;

    localparam int REG_IDX_W      = 5;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [REG_IDX_W-1:0] {
        ALU_ADD   = 5'b00000,
        ALU_SUB   = 5'b00001,
        ALU_AND   = 5'b00010,
        ALU_OR    = 5'b00011,
        ALU_XOR   = 5'b00100,
        ALU_NOR   = 5'b00101,
        ALU_SLT   = 5'b00110,
        ALU_SLTU  = 5'b00111,
        ALU_SLL   = 5'b01000,
        ALU_SRL   = 5'b01001,
        ALU_SRA   = 5'b01010,
        ALU_SLLV  = 5'b01011,
        ALU_SRLV  = 5'b01100,
        ALU_SRAV  = 5'b01101,
        ALU_LUI   = 5'b01110,
        ALU_MUL   = 5'b01111,
        ALU_MULH  = 5'b10000,
        ALU_MULHU = 5'b10001,
        ALU_DIV   = 5'b10010,
        ALU_MOD   = 5'b10011
    } alu_op_e;

    // Register 0 is hard-wired to zero, so it must never match a forwarding source.
    function automatic logic fwd_hit(input logic                 we,
                                     input logic [REG_IDX_W-1:0] src_rd,
                                     input logic [REG_IDX_W-1:0] idx);
        return we && (src_rd == idx) && (idx != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_select.sv
// ============================================================================
// Module      : fwd_select
// Description : Picks one ALU operand from mem / wb forwarding or register data
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fwd_select
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [DATA_W-1:0]    reg_data,
    input  logic                 mem_reg_write,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_result,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [DATA_W-1:0]    operand
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = fwd_hit(mem_reg_write, mem_rd, idx);
    assign w_wb_hit  = fwd_hit(wb_reg_write,  wb_rd,  idx);

    // The younger producer (mem) wins when both stages target the same register.
    always_comb begin
        operand = reg_data;
        if (w_mem_hit) begin
            operand = mem_result;
        end else if (w_wb_hit) begin
            operand = wb_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module      : alu_operand_stage
// Description : Decode-to-ALU pipeline register with forwarding and load-use stall
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_op,
    input  logic [REG_IDX_W-1:0] in_shamt,
    input  logic [REG_IDX_W-1:0] in_rs,
    input  logic [REG_IDX_W-1:0] in_rt,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [DATA_W-1:0]    in_rs_data,
    input  logic [DATA_W-1:0]    in_rt_data,
    input  logic [DATA_W-1:0]    in_imm,
    input  logic                 in_use_imm,
    input  logic                 in_reg_write,
    input  logic                 in_mem_read,
    input  logic                 flush,
    input  logic                 mem_reg_write,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_result,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [REG_IDX_W-1:0] ex_op,
    output logic [DATA_W-1:0]    ex_data1,
    output logic [DATA_W-1:0]    ex_data2,
    output logic [REG_IDX_W-1:0] ex_shamt,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic [CNT_W-1:0]     stall_count
);

    logic                 ex_valid_q,     ex_valid_d;
    logic [REG_IDX_W-1:0] ex_op_q,        ex_op_d;
    logic [DATA_W-1:0]    ex_data1_q,     ex_data1_d;
    logic [DATA_W-1:0]    ex_data2_q,     ex_data2_d;
    logic [REG_IDX_W-1:0] ex_shamt_q,     ex_shamt_d;
    logic [REG_IDX_W-1:0] ex_rd_q,        ex_rd_d;
    logic                 ex_reg_write_q, ex_reg_write_d;
    logic                 ex_mem_read_q,  ex_mem_read_d;
    logic [CNT_W-1:0]     stall_count_q,  stall_count_d;

    logic                 w_hazard;
    logic                 w_capture;
    logic [DATA_W-1:0]    w_fwd_rs;
    logic [DATA_W-1:0]    w_fwd_rt;

    // A load in ex cannot supply its data yet; a consumer behind it must wait.
    assign w_hazard = in_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                      ((ex_rd_q == in_rs) || ((ex_rd_q == in_rt) && !in_use_imm));

    assign in_ready  = (!ex_valid_q || ex_ready) && !w_hazard && !flush;
    assign w_capture = in_valid && in_ready;

    fwd_select #(
        .DATA_W        (DATA_W)
    ) u_fwd_rs (
        .idx           (in_rs),
        .reg_data      (in_rs_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .operand       (w_fwd_rs)
    );

    fwd_select #(
        .DATA_W        (DATA_W)
    ) u_fwd_rt (
        .idx           (in_rt),
        .reg_data      (in_rt_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .operand       (w_fwd_rt)
    );

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_op_d        = ex_op_q;
        ex_data1_d     = ex_data1_q;
        ex_data2_d     = ex_data2_q;
        ex_shamt_d     = ex_shamt_q;
        ex_rd_d        = ex_rd_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        stall_count_d  = stall_count_q;

        if (w_hazard && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end

        // Payload only moves on capture, so it stays stable across bubbles and flushes.
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (w_capture) begin
            ex_valid_d     = 1'b1;
            ex_op_d        = in_op;
            ex_data1_d     = w_fwd_rs;
            ex_data2_d     = in_use_imm ? in_imm : w_fwd_rt;
            ex_shamt_d     = in_shamt;
            ex_rd_d        = in_rd;
            ex_reg_write_d = in_reg_write;
            ex_mem_read_d  = in_mem_read;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_op_q        <= '0;
            ex_data1_q     <= '0;
            ex_data2_q     <= '0;
            ex_shamt_q     <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_op_q        <= ex_op_d;
            ex_data1_q     <= ex_data1_d;
            ex_data2_q     <= ex_data2_d;
            ex_shamt_q     <= ex_shamt_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_op        = ex_op_q;
    assign ex_data1     = ex_data1_q;
    assign ex_data2     = ex_data2_q;
    assign ex_shamt     = ex_shamt_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign stall_count  = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed and random checks of alu_operand_stage against a reference model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int C_CMAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op, in_shamt, in_rs, in_rt, in_rd;
    logic [DATA_W-1:0] in_rs_data, in_rt_data, in_imm;
    logic              in_use_imm, in_reg_write, in_mem_read;
    logic              flush;
    logic              mem_reg_write;
    logic [4:0]        mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              ex_ready;
    logic              ex_valid;
    logic [4:0]        ex_op, ex_shamt, ex_rd;
    logic [DATA_W-1:0] ex_data1, ex_data2;
    logic              ex_reg_write, ex_mem_read;
    logic [CNT_W-1:0]  stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit        m_valid, m_rw, m_mr;
    bit [4:0]  m_op, m_shamt, m_rd;
    bit [31:0] m_d1, m_d2;
    int        m_cnt;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_shamt(ex_shamt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .stall_count(stall_count)
    );

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] fwd(input bit [4:0] idx, input bit [31:0] rdata);
        if (idx == 0)                           return rdata;
        if (mem_reg_write && mem_rd == idx)     return mem_result;
        if (wb_reg_write && wb_rd == idx)       return wb_data;
        return rdata;
    endfunction

    function automatic bit m_hazard();
        bit rs_dep, rt_dep;
        rs_dep = (m_rd == in_rs);
        rt_dep = (m_rd == in_rt) && !in_use_imm;
        return in_valid && m_valid && m_mr && (m_rd != 0) && (rs_dep || rt_dep);
    endfunction

    function automatic bit m_ready();
        return (!m_valid || ex_ready) && !m_hazard() && !flush;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_op = 0; m_shamt = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit hz, rdy;
        hz  = m_hazard();
        rdy = m_ready();
        if (hz && m_cnt < C_CMAX) m_cnt++;
        if (flush) begin
            m_valid = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1;
            m_op    = in_op;
            m_shamt = in_shamt;
            m_rd    = in_rd;
            m_rw    = in_reg_write;
            m_mr    = in_mem_read;
            m_d1    = fwd(in_rs, in_rs_data);
            m_d2    = in_use_imm ? in_imm : fwd(in_rt, in_rt_data);
        end else if (ex_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk_eq({tag, ".ex_valid"},    ex_valid,     m_valid);
        chk_eq({tag, ".ex_op"},       ex_op,        m_op);
        chk_eq({tag, ".ex_data1"},    ex_data1,     m_d1);
        chk_eq({tag, ".ex_data2"},    ex_data2,     m_d2);
        chk_eq({tag, ".ex_shamt"},    ex_shamt,     m_shamt);
        chk_eq({tag, ".ex_rd"},       ex_rd,        m_rd);
        chk_eq({tag, ".ex_reg_write"},ex_reg_write, m_rw);
        chk_eq({tag, ".ex_mem_read"}, ex_mem_read,  m_mr);
        chk_eq({tag, ".stall_count"}, stall_count,  m_cnt);
    endtask

    // Inputs are already applied (after a negedge); check ready, clock, check state.
    task automatic cycle(input string tag);
        #1;
        chk_eq({tag, ".in_ready"}, in_ready, m_ready());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = 0; in_shamt = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0;
        in_use_imm = 0; in_reg_write = 0; in_mem_read = 0; flush = 0;
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
    endtask

    task automatic set_instr(input bit [4:0] op, input bit [4:0] rs, input bit [4:0] rt,
                             input bit [4:0] rd, input bit mr);
        in_valid = 1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_mem_read = mr; in_reg_write = 1; in_use_imm = 0;
        in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
    endtask

    task automatic rand_inputs();
        in_valid      = ($urandom_range(0, 3) != 0);
        in_op         = 5'($urandom_range(0, 19));
        in_shamt      = 5'($urandom_range(0, 31));
        in_rs         = 5'($urandom_range(0, 4));
        in_rt         = 5'($urandom_range(0, 4));
        in_rd         = 5'($urandom_range(0, 4));
        in_rs_data    = $urandom;
        in_rt_data    = $urandom;
        in_imm        = $urandom;
        in_use_imm    = $urandom_range(0, 1);
        in_reg_write  = $urandom_range(0, 1);
        in_mem_read   = ($urandom_range(0, 2) == 0);
        flush         = ($urandom_range(0, 9) == 0);
        mem_reg_write = $urandom_range(0, 1);
        mem_rd        = 5'($urandom_range(0, 4));
        mem_result    = $urandom;
        wb_reg_write  = $urandom_range(0, 1);
        wb_rd         = 5'($urandom_range(0, 4));
        wb_data       = $urandom;
        ex_ready      = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");

        @(negedge clk);
        rst_n = 1;

        // Forwarding: mem wins over wb on same index
        set_instr(5'b00000, 5'd1, 5'd2, 5'd3, 0);
        mem_reg_write = 1; mem_rd = 1; mem_result = 32'h10;
        wb_reg_write  = 1; wb_rd  = 1; wb_data    = 32'h20;
        cycle("fwd_mem");
        chk_eq("fwd_mem.const", ex_data1, 32'h10);

        // Register 0 never forwarded
        @(negedge clk);
        set_instr(5'b00000, 5'd0, 5'd0, 5'd5, 0);
        in_rs_data = 32'h1234_5678;
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'hFFFF;
        cycle("r0_nofwd");
        chk_eq("r0_nofwd.const", ex_data1, 32'h1234_5678);
        mem_reg_write = 0; wb_reg_write = 0;

        // Load-use: LW rd=4 then SUB rs=4
        @(negedge clk);
        set_instr(5'b00000, 5'd1, 5'd2, 5'd4, 1);
        cycle("lw");
        @(negedge clk);
        set_instr(5'b00001, 5'd4, 5'd2, 5'd6, 0);
        cycle("lu_stall");
        chk_eq("lu_stall.valid", ex_valid, 1'b0);
        chk_eq("lu_stall.cnt", stall_count, 4'd1);
        @(negedge clk);
        chk_eq("lu_resume.ready", in_ready, 1'b1);
        cycle("lu_resume");
        chk_eq("lu_resume.valid", ex_valid, 1'b1);
        chk_eq("lu_resume.op", ex_op, 5'b00001);

        // Backpressure hold for 3 cycles, then accept
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_instr(5'b00010, 5'd2, 5'd3, 5'd7, 0);
            ex_ready = 0;
            cycle("hold");
            chk_eq("hold.ready", in_ready, 1'b0);
            chk_eq("hold.op", ex_op, 5'b00001);
        end
        @(negedge clk);
        ex_ready = 1;
        cycle("hold_release");
        chk_eq("hold_release.op", ex_op, 5'b00010);

        // Flush beats capture
        @(negedge clk);
        set_instr(5'b00011, 5'd1, 5'd1, 5'd8, 0);
        flush = 1;
        cycle("flush");
        chk_eq("flush.valid", ex_valid, 1'b0);
        flush = 0;

        // Stall counter saturation with LW held under backpressure
        @(negedge clk);
        set_instr(5'b00000, 5'd1, 5'd2, 5'd4, 1);
        cycle("lw2");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_instr(5'b00001, 5'd3, 5'd4, 5'd6, 0);
            ex_ready = 0;
            cycle("sat");
        end
        chk_eq("sat.cnt", stall_count, C_CMAX);

        // Asynchronous reset while holding
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk_eq("async_rst.cnt", stall_count, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_inputs();
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
